instr_fetch_unit: RTL and testbench

Front-end fetch stage of the ARM pipeline.
- Generates the program counter and requests instruction words from instruction memory over a req/ack handshake.
- Buffers fetched words in a small FIFO and presents `{pc, instruction}` to the decode stage.
- Honours the decode-stage freeze (hazard) and redirects on a taken branch from execute, discarding wrong-path words, including an in-flight memory response.

---
 rtl/arm_pkg.sv | 26 ++
 rtl/instr_fetch_unit_if.sv | 21 ++
 rtl/fetch_fifo.sv | 64 ++++++
 rtl/instr_fetch_unit.sv | 118 +++++++++++
 tb/tb_instr_fetch_unit.sv | 350 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/arm_pkg.sv
// -----------------------------------------------------------------------------
// arm_pkg
// Types and constants shared by the fetch front end.
//   word_t        : 32-bit machine word
//   NOP_WORD      : MOV r0,r0, presented when no instruction is available
//   fetch_state_t : fetch sequencer states
//   fetch_entry_t : one fetch FIFO entry {pc, instr}
// -----------------------------------------------------------------------------
package arm_pkg;

    typedef logic [31:0] word_t;

    localparam word_t NOP_WORD = 32'hE1A0_0000;

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        DISCARD
    } fetch_state_t;

    typedef struct packed {
        word_t pc;     // fetch address + 4
        word_t instr;  // instruction word returned by memory
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_if
// Instruction-memory request/acknowledge bus.
//   imem_req   : request valid (fetch side drives)
//   imem_addr  : word-aligned byte address (fetch side drives)
//   imem_ack   : one-cycle response strobe (memory drives)
//   imem_rdata : instruction word, valid with imem_ack (memory drives)
// Modports: master = fetch unit, slave = instruction memory.
// -----------------------------------------------------------------------------
interface instr_fetch_unit_if;
    import arm_pkg::*;

    logic  imem_req;
    word_t imem_addr;
    logic  imem_ack;
    word_t imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);

endinterface

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// DEPTH-entry synchronous FIFO of {pc, instr} entries.
//   clk, rst : clock, asynchronous active-low reset
//   push     : write wr_data at the tail
//   pop      : drop the head entry
//   flush    : empty the FIFO; wins over push and pop
//   wr_data  : entry to write
//   head     : current head entry (meaningful only while count != 0)
//   count    : number of valid entries, 0..DEPTH
// The caller never pushes when full nor pops when empty.
// -----------------------------------------------------------------------------
module fetch_fifo
    import arm_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             wr_data,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    fetch_entry_t  mem [DEPTH];

    // NOTE: sequential state is updated only with non-blocking assignments so
    // every register samples values from before the clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array carries no reset; an entry is only ever read
    // after it has been written, and count alone says which entries are live.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wr_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Fetch stage: generates the program counter, requests words from instruction
// memory over a req/ack bus, buffers them in a small FIFO and presents the
// head {pc, instruction} to decode. Honours decode freeze and redirects on a
// taken branch, dropping wrong-path words including an in-flight response.
//   clk, rst     : clock, asynchronous active-low reset (shared with memory)
//   freeze       : decode stall; head entry is held
//   branch_taken : redirect request from execute
//   branch_addr  : redirect byte address
//   imem         : instruction-memory bus (master side)
//   inst_valid   : head entry valid
//   instruction  : head instruction, NOP_WORD when empty
//   pc           : head fetch address + 4, 0 when empty
// -----------------------------------------------------------------------------
module instr_fetch_unit
    import arm_pkg::*;
#(
    parameter int    DEPTH    = 2,
    parameter word_t RESET_PC = 32'h0000_0000,
    parameter word_t NOP_WORD = arm_pkg::NOP_WORD
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      freeze,
    input  logic                      branch_taken,
    input  word_t                     branch_addr,
    instr_fetch_unit_if.master        imem,
    output logic                      inst_valid,
    output word_t                     instruction,
    output word_t                     pc
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t  state;
    word_t         fetch_pc;   // next address to fetch
    word_t         held_addr;  // address of the outstanding request
    logic [CW-1:0] count;
    fetch_entry_t  head;
    fetch_entry_t  wr_entry;
    logic          req;
    logic          ack;
    logic          push;
    logic          pop;

    // NOTE: every signal written in an always_comb gets a default first so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        req = 1'b0;
        unique case (state)
            FETCH:         req = (count < CW'(DEPTH));
            WAIT, DISCARD: req = 1'b1;
            default:       req = 1'b0;
        endcase
    end

    // Requests are masked while reset is held so the bus idles; the request
    // may then rise in the very first cycle after reset is released.
    assign imem.imem_req  = rst && req;
    // In FETCH the live fetch_pc is on the bus; once a request is outstanding
    // the bus keeps the issued address even if a branch moves fetch_pc.
    assign imem.imem_addr = (state == FETCH) ? fetch_pc : held_addr;

    assign ack  = imem.imem_ack && req;
    assign push = ack && (state != DISCARD) && !branch_taken;
    assign pop  = inst_valid && !freeze && !branch_taken;

    always_comb begin
        wr_entry       = '0;
        wr_entry.pc    = fetch_pc + 32'd4;
        wr_entry.instr = imem.imem_rdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= FETCH;
            fetch_pc  <= RESET_PC;
            held_addr <= RESET_PC;
        end else begin
            if (state == FETCH) held_addr <= fetch_pc;

            if (branch_taken) begin
                // A request left unanswered this cycle must still be drained.
                fetch_pc <= {branch_addr[31:2], 2'b00};
                state    <= (req && !ack) ? DISCARD : FETCH;
            end else begin
                if (push) fetch_pc <= fetch_pc + 32'd4;
                unique case (state)
                    FETCH:   if (req && !ack) state <= WAIT;
                    WAIT:    if (ack)         state <= FETCH;
                    DISCARD: if (ack)         state <= FETCH;
                    default:                  state <= FETCH;
                endcase
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .flush   (branch_taken),
        .wr_data (wr_entry),
        .head    (head),
        .count   (count)
    );

    always_comb begin
        inst_valid  = (count != '0);
        instruction = inst_valid ? head.instr : NOP_WORD;
        pc          = inst_valid ? head.pc    : 32'd0;
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
// Self-checking bench for instr_fetch_unit. An instruction memory with
// programmable (fixed or random) latency answers requests with a word derived
// from the address. Directed scenarios plus a randomized run checked against
// an in-order program-stream model: the consumed stream must be target,
// target+4, ... after every branch, with nothing skipped or repeated.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;
    import arm_pkg::*;

    localparam int    DEPTH    = 2;
    localparam word_t RESET_PC = 32'h0000_0000;

    logic  clk = 1'b0;
    logic  rst = 1'b0;
    logic  freeze = 1'b0;
    logic  branch_taken = 1'b0;
    word_t branch_addr = '0;
    logic  inst_valid;
    word_t instruction;
    word_t pc;

    instr_fetch_unit_if bus ();

    instr_fetch_unit #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC),
        .NOP_WORD (NOP_WORD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem         (bus.master),
        .inst_valid   (inst_valid),
        .instruction  (instruction),
        .pc           (pc)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // ---------------- instruction memory model ----------------
    int lat_cfg    = 0;
    bit lat_random = 1'b0;
    int wait_cnt;
    int cur_lat;
    int eff_lat;

    function automatic word_t mem_word(input word_t a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    assign eff_lat        = lat_random ? cur_lat : lat_cfg;
    assign bus.imem_ack   = rst && bus.imem_req && (wait_cnt >= eff_lat);
    assign bus.imem_rdata = bus.imem_ack ? mem_word(bus.imem_addr) : 32'hDEAD_BEEF;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= 0;
            cur_lat  <= 0;
        end else if (bus.imem_ack) begin
            wait_cnt <= 0;
            cur_lat  <= int'($urandom_range(0, 3));
        end else if (bus.imem_req) begin
            wait_cnt <= wait_cnt + 1;
        end else begin
            wait_cnt <= 0;
        end
    end

    // ---------------- helpers ----------------
    task automatic do_reset(input int lat);
        rst          = 1'b0;
        freeze       = 1'b0;
        branch_taken = 1'b0;
        lat_random   = 1'b0;
        lat_cfg      = lat;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0;
        freeze = 1'b0;
        branch_taken = 1'b0;
        lat_cfg = 0;
        repeat (2) @(negedge clk);
        n_total++;
        if (bus.imem_req !== 1'b0) $display("FAIL reset_req: got %b, expected 0", bus.imem_req);
        else n_pass++;
        n_total++;
        if (bus.imem_addr !== RESET_PC) $display("FAIL reset_addr: got %h, expected %h", bus.imem_addr, RESET_PC);
        else n_pass++;
        n_total++;
        if ({inst_valid, instruction, pc} !== {1'b0, NOP_WORD, 32'd0})
            $display("FAIL reset_outputs: got valid=%b instr=%h pc=%h, expected 0/%h/0", inst_valid, instruction, pc, NOP_WORD);
        else n_pass++;
    endtask

    task automatic test_stream();
        word_t exp_addr;
        do_reset(0);
        #1;
        n_total++;
        if ({bus.imem_req, bus.imem_addr} !== {1'b1, RESET_PC})
            $display("FAIL first_req: got req=%b addr=%h, expected 1/%h", bus.imem_req, bus.imem_addr, RESET_PC);
        else n_pass++;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            exp_addr = RESET_PC + 32'(4 * k);
            n_total++;
            if (bus.imem_addr !== exp_addr) $display("FAIL stream_addr[%0d]: got %h, expected %h", k, bus.imem_addr, exp_addr);
            else n_pass++;
            n_total++;
            if ({inst_valid, pc, instruction} !== {1'b1, exp_addr, mem_word(exp_addr - 32'd4)})
                $display("FAIL stream_head[%0d]: got valid=%b pc=%h instr=%h, expected 1/%h/%h",
                         k, inst_valid, pc, instruction, exp_addr, mem_word(exp_addr - 32'd4));
            else n_pass++;
        end
    endtask

    task automatic test_freeze();
        word_t p0;
        word_t exp_pc;
        p0 = pc;
        freeze = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_total++;
            if ({inst_valid, pc, bus.imem_req} !== {1'b1, p0, 1'b0})
                $display("FAIL freeze_hold[%0d]: got valid=%b pc=%h req=%b, expected 1/%h/0", i, inst_valid, pc, bus.imem_req, p0);
            else n_pass++;
        end
        freeze = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            exp_pc = p0 + 32'(4 * i);
            n_total++;
            if ({inst_valid, pc, instruction} !== {1'b1, exp_pc, mem_word(exp_pc - 32'd4)})
                $display("FAIL freeze_release[%0d]: got valid=%b pc=%h instr=%h, expected 1/%h/%h",
                         i, inst_valid, pc, instruction, exp_pc, mem_word(exp_pc - 32'd4));
            else n_pass++;
        end
    endtask

    task automatic test_branch_wait();
        word_t next_addr;
        bit    got_next;
        do_reset(3);
        @(negedge clk);
        branch_taken = 1'b1;
        branch_addr  = 32'h0000_0100;
        @(negedge clk);
        branch_taken = 1'b0;
        n_total++;
        if ({inst_valid, bus.imem_req, bus.imem_addr} !== {1'b0, 1'b1, RESET_PC})
            $display("FAIL discard_hold: got valid=%b req=%b addr=%h, expected 0/1/%h", inst_valid, bus.imem_req, bus.imem_addr, RESET_PC);
        else n_pass++;
        got_next  = 1'b0;
        next_addr = '0;
        for (int c = 0; c < 40 && !inst_valid; c++) begin
            @(negedge clk);
            if (!got_next && bus.imem_addr !== RESET_PC) begin
                got_next  = 1'b1;
                next_addr = bus.imem_addr;
            end
        end
        n_total++;
        if (next_addr !== 32'h0000_0100) $display("FAIL branch_next_addr: got %h, expected 00000100", next_addr);
        else n_pass++;
        n_total++;
        if ({inst_valid, pc, instruction} !== {1'b1, 32'h0000_0104, mem_word(32'h0000_0100)})
            $display("FAIL branch_first_word: got valid=%b pc=%h instr=%h, expected 1/00000104/%h",
                     inst_valid, pc, instruction, mem_word(32'h0000_0100));
        else n_pass++;
    endtask

    task automatic test_branch_ack_freeze();
        do_reset(0);
        repeat (3) @(negedge clk);
        freeze       = 1'b1;
        branch_taken = 1'b1;
        branch_addr  = 32'h0000_2000;
        @(negedge clk);
        branch_taken = 1'b0;
        freeze       = 1'b0;
        n_total++;
        if ({inst_valid, instruction, pc} !== {1'b0, NOP_WORD, 32'd0})
            $display("FAIL bra_ack_flush: got valid=%b instr=%h pc=%h, expected 0/%h/0", inst_valid, instruction, pc, NOP_WORD);
        else n_pass++;
        n_total++;
        if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h0000_2000})
            $display("FAIL bra_ack_addr: got req=%b addr=%h, expected 1/00002000", bus.imem_req, bus.imem_addr);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({inst_valid, pc, instruction} !== {1'b1, 32'h0000_2004, mem_word(32'h0000_2000)})
            $display("FAIL bra_ack_first: got valid=%b pc=%h instr=%h, expected 1/00002004/%h",
                     inst_valid, pc, instruction, mem_word(32'h0000_2000));
        else n_pass++;
    endtask

    task automatic test_double_branch();
        bit saw_first;
        do_reset(5);
        @(negedge clk);
        branch_taken = 1'b1;
        branch_addr  = 32'h0000_0300;
        @(negedge clk);
        branch_taken = 1'b0;
        @(negedge clk);
        branch_taken = 1'b1;
        branch_addr  = 32'h0000_0400;
        @(negedge clk);
        branch_taken = 1'b0;
        saw_first = 1'b0;
        for (int c = 0; c < 60 && !inst_valid; c++) begin
            @(negedge clk);
            if (bus.imem_req && bus.imem_addr === 32'h0000_0300) saw_first = 1'b1;
        end
        n_total++;
        if (saw_first !== 1'b0) $display("FAIL dbl_branch_stale: got fetch of 00000300=%b, expected 0", saw_first);
        else n_pass++;
        n_total++;
        if ({inst_valid, pc, instruction} !== {1'b1, 32'h0000_0404, mem_word(32'h0000_0400)})
            $display("FAIL dbl_branch_first: got valid=%b pc=%h instr=%h, expected 1/00000404/%h",
                     inst_valid, pc, instruction, mem_word(32'h0000_0400));
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit found;
        do_reset(2);
        freeze = 1'b1;
        found  = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            @(negedge clk);
            if (inst_valid && bus.imem_req && !bus.imem_ack) found = 1'b1;
        end
        n_total++;
        if (found !== 1'b1) $display("FAIL rst_mid_setup: got outstanding-with-data=%b, expected 1", found);
        else n_pass++;
        #2;
        rst = 1'b0;
        #1;
        n_total++;
        if ({bus.imem_req, bus.imem_addr, inst_valid, instruction, pc} !== {1'b0, RESET_PC, 1'b0, NOP_WORD, 32'd0})
            $display("FAIL rst_mid_outputs: got req=%b addr=%h valid=%b instr=%h pc=%h, expected 0/%h/0/%h/0",
                     bus.imem_req, bus.imem_addr, inst_valid, instruction, pc, RESET_PC, NOP_WORD);
        else n_pass++;
        @(negedge clk);
        freeze = 1'b0;
        rst    = 1'b1;
        #1;
        n_total++;
        if ({bus.imem_req, bus.imem_addr} !== {1'b1, RESET_PC})
            $display("FAIL rst_mid_restart: got req=%b addr=%h, expected 1/%h", bus.imem_req, bus.imem_addr, RESET_PC);
        else n_pass++;
        for (int c = 0; c < 20 && !inst_valid; c++) @(negedge clk);
        n_total++;
        if ({inst_valid, pc, instruction} !== {1'b1, RESET_PC + 32'd4, mem_word(RESET_PC)})
            $display("FAIL rst_mid_first: got valid=%b pc=%h instr=%h, expected 1/%h/%h",
                     inst_valid, pc, instruction, RESET_PC + 32'd4, mem_word(RESET_PC));
        else n_pass++;
    endtask

    task automatic test_random();
        word_t exp_pc;
        word_t target;
        bit    prev_br;
        bit    br;
        bit    fr;
        int    pops;
        do_reset(0);
        lat_random = 1'b1;
        exp_pc  = RESET_PC;
        prev_br = 1'b0;
        pops    = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (prev_br) begin
                n_total++;
                if (inst_valid !== 1'b0) $display("FAIL rnd_after_branch[%0d]: got valid=%b, expected 0", cyc, inst_valid);
                else n_pass++;
            end
            if (!inst_valid) begin
                n_total++;
                if ({instruction, pc} !== {NOP_WORD, 32'd0})
                    $display("FAIL rnd_empty[%0d]: got instr=%h pc=%h, expected %h/0", cyc, instruction, pc, NOP_WORD);
                else n_pass++;
            end else begin
                n_total++;
                if ({pc, instruction} !== {exp_pc + 32'd4, mem_word(exp_pc)})
                    $display("FAIL rnd_head[%0d]: got pc=%h instr=%h, expected %h/%h",
                             cyc, pc, instruction, exp_pc + 32'd4, mem_word(exp_pc));
                else n_pass++;
            end
            n_total++;
            if (bus.imem_addr[1:0] !== 2'b00) $display("FAIL rnd_align[%0d]: got addr=%h, expected low bits 00", cyc, bus.imem_addr);
            else n_pass++;

            br = ($urandom_range(0, 99) < 6);
            fr = ($urandom_range(0, 99) < 30);
            if ($urandom_range(0, 3) == 0) target = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 32'd4;
            else                           target = $urandom & 32'hFFFF_FFFC;
            branch_taken = br;
            branch_addr  = target;
            freeze       = fr;
            if (br) begin
                exp_pc = target;
            end else if (inst_valid && !fr) begin
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            prev_br = br;
            @(negedge clk);
        end
        branch_taken = 1'b0;
        freeze       = 1'b0;
        n_total++;
        if (pops < 40) $display("FAIL rnd_progress: got %0d words consumed, expected at least 40", pops);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_freeze();
        test_branch_wait();
        test_branch_ack_freeze();
        test_double_branch();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached before the summary");
        $fatal(1, "time limit");
    end

endmodule
